// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants used by the receiver, the transmitter and the receive FIFO.
package uart_rx_fifo_pkg;
    localparam int DBIT_DEF   = 8;
    localparam int ADDR_W_DEF = 4;
    localparam int SB_TICK    = 16;
endpackage

// File: rtl/uart_rx_fifo_ctrl.sv
// FIFO bookkeeping: read/write pointers, occupancy count, full/empty flags and the accept decision.
module fifo_ctrl
    import uart_rx_fifo_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] r_addr,
    output logic              wr_en,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W - 1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_w_ptr;
    logic [ADDR_W-1:0] r_r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_w_next;
    logic [ADDR_W-1:0] w_r_next;

    // A push into a full FIFO is still accepted when a pop frees the head slot in the same cycle.
    assign w_push   = wr & (~r_full | rd);
    assign w_pop    = rd & ~r_empty;
    assign w_w_next = r_w_ptr + PTR_ONE;
    assign w_r_next = r_r_ptr + PTR_ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_w_ptr <= '0;
            r_r_ptr <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_w_ptr <= w_w_next;
            if (w_pop)  r_r_ptr <= w_r_next;
            case ({w_push, w_pop})
                2'b10: begin
                    r_count <= r_count + CNT_ONE;
                    r_empty <= 1'b0;
                    r_full  <= (w_w_next == r_r_ptr);
                end
                2'b01: begin
                    r_count <= r_count - CNT_ONE;
                    r_full  <= 1'b0;
                    r_empty <= (w_r_next == r_w_ptr);
                end
                default: ;
            endcase
        end
    end

    assign w_addr = r_w_ptr;
    assign r_addr = r_r_ptr;
    assign wr_en  = w_push;
    assign full   = r_full;
    assign empty  = r_empty;
    assign count  = r_count;
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART receiver, with occupancy count and sticky overflow flag.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int DBIT   = DBIT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic [DBIT-1:0]   w_data,
    input  logic              rd,
    output logic [DBIT-1:0]   r_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DBIT-1:0]   r_mem [DEPTH];
    logic              r_overflow;
    logic [ADDR_W-1:0] w_w_addr;
    logic [ADDR_W-1:0] w_r_addr;
    logic              w_wr_en;
    logic              w_full;

    fifo_ctrl #(.ADDR_W(ADDR_W)) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .rd     (rd),
        .w_addr (w_w_addr),
        .r_addr (w_r_addr),
        .wr_en  (w_wr_en),
        .full   (w_full),
        .empty  (empty),
        .count  (count)
    );

    // Storage is deliberately not reset; the flags make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_w_addr] <= w_data;
    end

    assign r_data = r_mem[w_r_addr];

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (reset)                      r_overflow <= 1'b0;
        else if (wr && w_full && !rd)   r_overflow <= 1'b1;
        else if (clr_ovf)               r_overflow <= 1'b0;
    end

    assign full     = w_full;
    assign overflow = r_overflow;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scenario bench for uart_rx_fifo: a reference queue holds expected bytes in FIFO order.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] w_data = '0;
    logic       rd = 1'b0;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       clr_ovf = 1'b0;

    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       last_pop;
    logic [7:0] last_act;
    logic [7:0] last_exp;
    int         n_pass = 0;
    int         n_total = 0;

    uart_rx_fifo dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .w_data   (w_data),
        .rd       (rd),
        .r_data   (r_data),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; updates the reference queue and captures the popped head.
    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        int   sz;
        logic pop_ok;
        logic push_ok;
        sz      = exp_q.size();
        pop_ok  = r && (sz != 0);
        push_ok = w && ((sz < DEPTH) || r);
        wr = w; w_data = d; rd = r; clr_ovf = c;
        last_pop = pop_ok;
        if (pop_ok) begin
            last_act = r_data;
            last_exp = exp_q.pop_front();
        end
        if (push_ok) exp_q.push_back(d);
        if (w && (sz == DEPTH) && !r) m_ovf = 1'b1;
        else if (c)                   m_ovf = 1'b0;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0; clr_ovf = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (empty !== 1'b1) $display("FAIL reset_empty act=%b exp=1", empty); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full act=%b exp=0", full); else n_pass++;
        n_total++; if (count !== 5'd0) $display("FAIL reset_count act=%0d exp=0", count); else n_pass++;
        n_total++; if (overflow !== 1'b0) $display("FAIL reset_ovf act=%b exp=0", overflow); else n_pass++;
    endtask

    task automatic test_single();
        drive(1'b1, 8'hA5, 1'b0, 1'b0);
        n_total++; if (empty !== 1'b0) $display("FAIL single_empty act=%b exp=0", empty); else n_pass++;
        n_total++; if (count !== 5'd1) $display("FAIL single_count act=%0d exp=1", count); else n_pass++;
        n_total++; if (r_data !== 8'hA5) $display("FAIL single_data act=%h exp=a5", r_data); else n_pass++;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_total++; if (!last_pop || last_act !== last_exp) $display("FAIL single_pop act=%h exp=%h", last_act, last_exp); else n_pass++;
        n_total++; if (empty !== 1'b1 || count !== 5'd0) $display("FAIL single_drain act=%b/%0d exp=1/0", empty, count); else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        n_total++; if (full !== 1'b1 || count !== 5'd16) $display("FAIL fill_full act=%b/%0d exp=1/16", full, count); else n_pass++;
        n_total++; if (empty !== 1'b0) $display("FAIL fill_empty act=%b exp=0", empty); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            n_total++; if (!last_pop || last_act !== last_exp || last_act !== 8'(i)) $display("FAIL drain_data idx=%0d act=%h exp=%h", i, last_act, 8'(i)); else n_pass++;
        end
        n_total++; if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0) $display("FAIL drain_end act=%b/%b/%0d exp=1/0/0", empty, full, count); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom_range(0, 254)), 1'b0, 1'b0);
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        n_total++; if (overflow !== 1'b1) $display("FAIL ovf_set act=%b exp=1", overflow); else n_pass++;
        n_total++; if (count !== 5'd16 || full !== 1'b1) $display("FAIL ovf_count act=%0d exp=16", count); else n_pass++;
        drive(1'b1, 8'hFF, 1'b0, 1'b1);
        n_total++; if (overflow !== m_ovf || overflow !== 1'b1) $display("FAIL ovf_set_wins act=%b exp=1", overflow); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            n_total++; if (!last_pop || last_act !== last_exp || last_act === 8'hFF) $display("FAIL ovf_data idx=%0d act=%h exp=%h", i, last_act, last_exp); else n_pass++;
        end
        n_total++; if (overflow !== 1'b1 || empty !== 1'b1) $display("FAIL ovf_sticky act=%b/%b exp=1/1", overflow, empty); else n_pass++;
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear act=%b exp=0", overflow); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            n_total++; if (!last_pop || last_act !== last_exp) $display("FAIL b2b_data cyc=%0d act=%h exp=%h", i, last_act, last_exp); else n_pass++;
            n_total++; if (count !== 5'd8) $display("FAIL b2b_count cyc=%0d act=%0d exp=8", i, count); else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            n_total++; if (!last_pop || last_act !== last_exp) $display("FAIL b2b_drain idx=%0d act=%h exp=%h", i, last_act, last_exp); else n_pass++;
        end
        n_total++; if (empty !== 1'b1 || count !== 5'd0) $display("FAIL b2b_end act=%b/%0d exp=1/0", empty, count); else n_pass++;
    endtask

    task automatic test_simultaneous_edges();
        do_reset();
        drive(1'b1, 8'h3C, 1'b1, 1'b0);
        n_total++; if (count !== 5'd1 || empty !== 1'b0) $display("FAIL sim_empty_count act=%0d exp=1", count); else n_pass++;
        n_total++; if (r_data !== 8'h3C) $display("FAIL sim_empty_data act=%h exp=3c", r_data); else n_pass++;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_total++; if (!last_pop || last_act !== 8'h3C) $display("FAIL sim_pop act=%h exp=3c", last_act); else n_pass++;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_total++; if (empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0) $display("FAIL rd_on_empty act=%b/%0d exp=1/0", empty, count); else n_pass++;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        n_total++; if (!last_pop || last_act !== last_exp) $display("FAIL sim_full_pop act=%h exp=%h", last_act, last_exp); else n_pass++;
        n_total++; if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) $display("FAIL sim_full act=%0d/%b/%b exp=16/1/0", count, full, overflow); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            n_total++; if (!last_pop || last_act !== last_exp) $display("FAIL sim_drain idx=%0d act=%h exp=%h", i, last_act, last_exp); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        n_total++; if (count !== 5'd5) $display("FAIL mid_pre_count act=%0d exp=5", count); else n_pass++;
        do_reset();
        n_total++; if (empty !== 1'b1 || count !== 5'd0 || overflow !== 1'b0 || full !== 1'b0) $display("FAIL mid_reset act=%b/%0d/%b exp=1/0/0", empty, count, overflow); else n_pass++;
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        n_total++; if (r_data !== 8'h11 || count !== 5'd1) $display("FAIL mid_push act=%h/%0d exp=11/1", r_data, count); else n_pass++;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        n_total++; if (!last_pop || last_act !== last_exp || empty !== 1'b1) $display("FAIL mid_pop act=%h exp=%h", last_act, last_exp); else n_pass++;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_fill_drain();
        test_overflow();
        test_back_to_back();
        test_simultaneous_edges();
        test_reset_mid();
        n_total++; if (exp_q.size() != 0) $display("FAIL scoreboard_left act=%0d exp=0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
